// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_reg
// Brief    : Pipeline stage register with two-entry skid buffer, flush and
//            saturating back-pressure counter.
// Revision : 1.0
// ============================================================================
module pipe_skid_reg #(
    parameter int DATA_W         = 256,
    parameter bit CLEAR_ON_FLUSH = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall_cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_main;
    logic [DATA_W-1:0]   w_main_nxt;
    logic [DATA_W-1:0]   r_skid;
    logic [DATA_W-1:0]   w_skid_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_stall;

    // in_ready is a function of registered state and reset only, so the
    // upstream ready path never sees downstream combinational logic.
    assign in_ready   = (r_state != ST_SKID) & rst;
    assign out_valid  = (r_state != ST_EMPTY);
    assign out_data   = r_main;
    assign stall_cnt  = r_cnt;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_stall    = out_valid & ~out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            // Any input fire in this cycle is swallowed; an output fire counts as delivered.
            w_state_nxt = ST_EMPTY;
            if (CLEAR_ON_FLUSH) begin
                w_main_nxt = '0;
                w_skid_nxt = '0;
            end
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_nxt  = in_data;
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = in_data;
                    end else if (w_in_fire) begin
                        w_skid_nxt  = in_data;
                        w_state_nxt = ST_SKID;
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (w_out_fire) begin
                        w_main_nxt  = r_skid;
                        w_state_nxt = ST_FULL;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // Flush leaves the counter alone; clear beats increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (stall_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_stall && !(&r_cnt)) begin
            r_cnt <= r_cnt + C_CNT_ONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_reg
// Brief    : Directed self-checking bench for pipe_skid_reg (two flush variants).
// Revision : 1.0
// ============================================================================
module tb_pipe_skid_reg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;
    logic              stall_cnt_clr;
    logic              in_ready_a,  in_ready_b;
    logic              out_valid_a, out_valid_b;
    logic [DATA_W-1:0] out_data_a,  out_data_b;
    logic [CNT_W-1:0]  stall_cnt_a, stall_cnt_b;

    int checks = 0;
    int errors = 0;

    pipe_skid_reg #(.DATA_W(DATA_W), .CLEAR_ON_FLUSH(1'b1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .stall_cnt_clr(stall_cnt_clr), .stall_cnt(stall_cnt_a)
    );

    pipe_skid_reg #(.DATA_W(DATA_W), .CLEAR_ON_FLUSH(1'b0), .CNT_W(CNT_W)) dut_hold (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .stall_cnt_clr(stall_cnt_clr), .stall_cnt(stall_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'h00;
        out_ready = 1'b0; stall_cnt_clr = 1'b0;
        repeat (3) step();
        checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready_a); end
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid_a); end
        checks++; if (stall_cnt_a !== 4'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt_a); end
        checks++; if (out_data_a !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data_a); end
        rst = 1'b0; in_valid = 1'b0;
        rst = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready_a); end
        in_valid = 1'b1; in_data = 8'hA5;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid_a !== 1'b1 || out_data_a !== 8'hA5) begin
            errors++; $display("FAIL first_entry got v=%b d=%h want v=1 d=a5", out_valid_a, out_data_a); end
        step();
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL first_drain got %b want 0", out_valid_a); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'd0;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++; if (out_valid_a !== 1'b1 || out_data_a !== 8'(i) || in_ready_a !== 1'b1) begin
                errors++; $display("FAIL stream_%0d got v=%b d=%0d rdy=%b want v=1 d=%0d rdy=1",
                                   i, out_valid_a, out_data_a, in_ready_a, i); end
            if (i < 15) in_data = 8'(i + 1);
            else in_valid = 1'b0;
        end
        step();
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL stream_drain got %b want 0", out_valid_a); end
        checks++; if (stall_cnt_a !== 4'd0) begin errors++; $display("FAIL stream_stall_cnt got %0d want 0", stall_cnt_a); end
    endtask

    task automatic test_skid();
        stall_cnt_clr = 1'b1; step(); stall_cnt_clr = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;  // A
        step();
        in_data = 8'h22;                                     // B
        step();
        in_data = 8'h33;                                     // C held upstream
        step();
        step();
        checks++; if (out_valid_a !== 1'b1 || out_data_a !== 8'h11) begin
            errors++; $display("FAIL skid_main got v=%b d=%h want v=1 d=11", out_valid_a, out_data_a); end
        checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL skid_in_ready got %b want 0", in_ready_a); end
        checks++; if (stall_cnt_a !== 4'd3) begin errors++; $display("FAIL skid_stall_cnt got %0d want 3", stall_cnt_a); end
        out_ready = 1'b1;
        step();
        checks++; if (out_data_a !== 8'h22 || in_ready_a !== 1'b1) begin
            errors++; $display("FAIL skid_recover got d=%h rdy=%b want d=22 rdy=1", out_data_a, in_ready_a); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid_a !== 1'b1 || out_data_a !== 8'h33) begin
            errors++; $display("FAIL skid_third got v=%b d=%h want v=1 d=33", out_valid_a, out_data_a); end
        step();
        checks++; if (out_valid_a !== 1'b0 || stall_cnt_a !== 4'd3) begin
            errors++; $display("FAIL skid_drain got v=%b cnt=%0d want v=0 cnt=3", out_valid_a, stall_cnt_a); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h3C;  // A
        step();
        in_data = 8'h4D;                                     // B
        step();
        checks++; if (in_ready_a !== 1'b0 || out_data_a !== 8'h3C) begin
            errors++; $display("FAIL flush_pre got rdy=%b d=%h want rdy=0 d=3c", in_ready_a, out_data_a); end
        flush = 1'b1; in_data = 8'h77;                       // D
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
            errors++; $display("FAIL flush_state got v=%b rdy=%b want v=0 rdy=1", out_valid_a, in_ready_a); end
        checks++; if (out_data_a !== 8'h00) begin errors++; $display("FAIL flush_clear_data got %h want 00", out_data_a); end
        checks++; if (out_valid_b !== 1'b0 || out_data_b !== 8'h3C) begin
            errors++; $display("FAIL flush_hold_data got v=%b d=%h want v=0 d=3c", out_valid_b, out_data_b); end
        step();
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL flush_no_d got %b want 0", out_valid_a); end
        // Flush from FULL while an input fires: the new entry is discarded.
        in_valid = 1'b1; in_data = 8'h5E;
        step();
        in_data = 8'h6F; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        step();
        checks++; if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
            errors++; $display("FAIL flush_in_fire got v=%b/%b want 0/0", out_valid_a, out_valid_b); end
    endtask

    task automatic test_counter();
        stall_cnt_clr = 1'b1; step(); stall_cnt_clr = 1'b0;
        checks++; if (stall_cnt_a !== 4'd0) begin errors++; $display("FAIL cnt_clear got %0d want 0", stall_cnt_a); end
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h99;
        step();
        in_valid = 1'b0;
        repeat (14) step();
        checks++; if (stall_cnt_a !== 4'd14) begin errors++; $display("FAIL cnt_14 got %0d want 14", stall_cnt_a); end
        repeat (6) step();
        checks++; if (stall_cnt_a !== 4'd15) begin errors++; $display("FAIL cnt_saturate got %0d want 15", stall_cnt_a); end
        stall_cnt_clr = 1'b1;
        step();
        stall_cnt_clr = 1'b0;
        checks++; if (stall_cnt_a !== 4'd0) begin errors++; $display("FAIL cnt_clr_wins got %0d want 0", stall_cnt_a); end
        step();
        checks++; if (stall_cnt_a !== 4'd1) begin errors++; $display("FAIL cnt_resume got %0d want 1", stall_cnt_a); end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_data = 8'hAB;
        step();
        in_valid = 1'b0;
        checks++; if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1) begin
            errors++; $display("FAIL areset_pre got rdy=%b v=%b want rdy=0 v=1", in_ready_a, out_valid_a); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b0 || out_data_a !== 8'h00 || stall_cnt_a !== 4'd0) begin
            errors++; $display("FAIL areset_assert got v=%b rdy=%b d=%h cnt=%0d want 0/0/00/0",
                               out_valid_a, in_ready_a, out_data_a, stall_cnt_a); end
        rst = 1'b1;
        #1;
        checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
            errors++; $display("FAIL areset_release got rdy=%b v=%b want rdy=1 v=0", in_ready_a, out_valid_a); end
        step();
        checks++; if (out_valid_a !== 1'b0 || stall_cnt_a !== 4'd0) begin
            errors++; $display("FAIL areset_idle got v=%b cnt=%0d want 0/0", out_valid_a, stall_cnt_a); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_counter();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
